// File: rtl/biestable_t_pkg.sv
// -----------------------------------------------------------------------------
// biestable_t_pkg
// Shared defaults and helpers for the watchdog toggle bistable.
//   SYNC_STAGES_DEF    : default synchronizer depth on the kick input
//   CNT_W_DEF          : default kick counter width
//   TIMEOUT_CYCLES_DEF : default missed-kick timeout in clock cycles
//   idle_width()       : width of the idle counter so it can hold TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
package biestable_t_pkg;

    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned CNT_W_DEF          = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

    // ceil(log2(t+1)): enough bits to represent the value t itself.
    function automatic int unsigned idle_width(input int unsigned t);
        return $clog2(t + 1);
    endfunction

endpackage : biestable_t_pkg

// File: rtl/biestable_t_sync.sv
// -----------------------------------------------------------------------------
// biestable_t_sync
// Plain N-flop synchronizer for a single asynchronous bit. No reset: the chain
// simply follows its input, so it settles after STAGES clocks.
// Ports:
//   clk_i : sampling clock
//   d_i   : asynchronous input
//   q_o   : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module biestable_t_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    if (STAGES < 2) begin : g_chk
        $error("biestable_t_sync: STAGES must be at least 2");
    end

    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule : biestable_t_sync

// File: rtl/biestable_t.sv
// -----------------------------------------------------------------------------
// biestable_t
// Watchdog toggle flip-flop. Every rising edge seen on the kick input flips
// wdgOut, producing the square-wave heartbeat the board supervisor expects.
// Also counts kicks (wrapping) and flags a missed-kick timeout.
//
// Optional build macro BIESTABLE_T_SYNC_EN: when defined, wdg passes through a
// SYNC_STAGES-deep synchronizer before edge detection (for asynchronous kick
// sources). When undefined, wdg must already be synchronous to clk.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   wdg      : watchdog kick level; only rising edges matter
//   wdgOut   : registered toggle output
//   kick_cnt : registered count of detected rising edges, wraps
//   timeout  : registered, high while no kick for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module biestable_t
    import biestable_t_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wdg,
    output logic             wdgOut,
    output logic [CNT_W-1:0] kick_cnt,
    output logic             timeout
);

    localparam int unsigned IDLE_W = idle_width(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    // Parameter legality, checked at elaboration in every build.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("biestable_t: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 24'hFF_FFFF) begin : g_bad_tmo
        $error("biestable_t: TIMEOUT_CYCLES must be in 1..2^24-1");
    end

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic wdg_s;

`ifdef BIESTABLE_T_SYNC_EN
    biestable_t_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .d_i   (wdg),
        .q_o   (wdg_s)
    );
`else
    assign wdg_s = wdg;
`endif

    // The previous-level flop keeps tracking through reset, so a level that is
    // already high when reset releases is not mistaken for a fresh kick.
    logic wdg_prev_q;

    always_ff @(posedge clk) begin
        wdg_prev_q <= wdg_s;
    end

    logic rise;
    assign rise = wdg_s & ~wdg_prev_q;

    // ------------------------------------------------------------------
    // Toggle, kick counter, idle counter, timeout
    // ------------------------------------------------------------------
    logic              wdg_out_q,  wdg_out_d;
    logic [CNT_W-1:0]  kick_cnt_q, kick_cnt_d;
    logic [IDLE_W-1:0] idle_q,     idle_d;
    logic              timeout_q,  timeout_d;

    always_comb begin
        wdg_out_d  = wdg_out_q ^ rise;
        kick_cnt_d = rise ? kick_cnt_q + CNT_W'(1) : kick_cnt_q;

        // A kick always wins, even on the edge where the counter saturates.
        if (rise) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end

        // Look at the next idle value so timeout lands exactly TIMEOUT_CYCLES
        // edges after the last kick or reset release.
        timeout_d = (idle_d == IDLE_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdg_out_q  <= 1'b0;
            kick_cnt_q <= '0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wdg_out_q  <= wdg_out_d;
            kick_cnt_q <= kick_cnt_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
        end
    end

    assign wdgOut   = wdg_out_q;
    assign kick_cnt = kick_cnt_q;
    assign timeout  = timeout_q;

endmodule : biestable_t

// File: tb/tb_biestable_t.sv
// -----------------------------------------------------------------------------
// tb_biestable_t
// Directed bench for the watchdog toggle bistable. The DUT is built with a
// 3-bit kick counter and a 10-cycle timeout so wrap and timeout are reachable.
// -----------------------------------------------------------------------------
module tb_biestable_t;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned TMO         = 10;

`ifdef BIESTABLE_T_SYNC_EN
    localparam int LAT = SYNC_STAGES + 1;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wdg = 1'b0;
    logic             wdgOut;
    logic [CNT_W-1:0] kick_cnt;
    logic             timeout;

    int tests_run = 0;
    int fails     = 0;

    biestable_t #(
        .SYNC_STAGES    (SYNC_STAGES),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wdg      (wdg),
        .wdgOut   (wdgOut),
        .kick_cnt (kick_cnt),
        .timeout  (timeout)
    );

    always #10 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the edge for sampling/driving.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        wdg = lvl;
        tick(6);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wdg = 1'b0;
        tick(3);
        tests_run++;
        if (wdgOut !== 1'b0) begin
            fails++; $display("FAIL reset_wdgOut got=%b exp=0", wdgOut);
        end
        tests_run++;
        if (kick_cnt !== 3'd0) begin
            fails++; $display("FAIL reset_kick_cnt got=%0d exp=0", kick_cnt);
        end
        tests_run++;
        if (timeout !== 1'b0) begin
            fails++; $display("FAIL reset_timeout got=%b exp=0", timeout);
        end
        tick(3);
        rst = 1'b0;
    endtask

    task automatic test_toggle;
        logic exp_out;
        exp_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdg = 1'b1;
            tick(LAT - 1);
            tests_run++;
            if (wdgOut !== exp_out) begin
                fails++; $display("FAIL toggle_early kick=%0d got=%b exp=%b", i, wdgOut, exp_out);
            end
            tick(1);
            exp_out = ~exp_out;
            tests_run++;
            if (wdgOut !== exp_out) begin
                fails++; $display("FAIL toggle_flip kick=%0d got=%b exp=%b", i, wdgOut, exp_out);
            end
            tick(2);
            wdg = 1'b0;
            tick(LAT + 2);
            tests_run++;
            if (wdgOut !== exp_out || kick_cnt !== 3'(i + 1)) begin
                fails++; $display("FAIL toggle_hold kick=%0d got=%b/%0d exp=%b/%0d",
                                  i, wdgOut, kick_cnt, exp_out, i + 1);
            end
        end
        tests_run++;
        if (kick_cnt !== 3'd4) begin
            fails++; $display("FAIL toggle_count got=%0d exp=4", kick_cnt);
        end
    endtask

    task automatic test_level_at_release;
        do_reset(1'b1);
        tick(LAT + 3);
        tests_run++;
        if (wdgOut !== 1'b0) begin
            fails++; $display("FAIL level_wdgOut got=%b exp=0", wdgOut);
        end
        tests_run++;
        if (kick_cnt !== 3'd0) begin
            fails++; $display("FAIL level_kick_cnt got=%0d exp=0", kick_cnt);
        end
        wdg = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_timeout;
        do_reset(1'b0);
        tick(TMO - 1);
        tests_run++;
        if (timeout !== 1'b0) begin
            fails++; $display("FAIL timeout_early got=%b exp=0", timeout);
        end
        tick(1);
        tests_run++;
        if (timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_rise got=%b exp=1", timeout);
        end
        tick(5);
        tests_run++;
        if (timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_hold got=%b exp=1", timeout);
        end
        // Kick while the idle counter is saturated.
        wdg = 1'b1;
        tick(LAT - 1);
        tests_run++;
        if (timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_prekick got=%b exp=1", timeout);
        end
        tick(1);
        tests_run++;
        if (timeout !== 1'b0) begin
            fails++; $display("FAIL timeout_kick_clear got=%b exp=0", timeout);
        end
        tick(TMO - 1);
        tests_run++;
        if (timeout !== 1'b0) begin
            fails++; $display("FAIL timeout_rearm_early got=%b exp=0", timeout);
        end
        tick(1);
        tests_run++;
        if (timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_rearm got=%b exp=1", timeout);
        end
        wdg = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic test_wrap;
        do_reset(1'b0);
        for (int i = 1; i <= 9; i++) begin
            wdg = 1'b1;
            tick(LAT + 1);
            wdg = 1'b0;
            tick(LAT + 1);
            if (i == 7 || i == 8) begin
                tests_run++;
                if (kick_cnt !== 3'(i)) begin
                    fails++; $display("FAIL wrap_step kicks=%0d got=%0d exp=%0d", i, kick_cnt, i % 8);
                end
            end
        end
        tests_run++;
        if (kick_cnt !== 3'd1) begin
            fails++; $display("FAIL wrap_final got=%0d exp=1", kick_cnt);
        end
        tests_run++;
        if (wdgOut !== 1'b1) begin
            fails++; $display("FAIL wrap_wdgOut got=%b exp=1", wdgOut);
        end
    endtask

    task automatic test_reset_priority;
        do_reset(1'b0);
        wdg = 1'b1;
        tick(LAT + 1);
        wdg = 1'b0;
        tick(LAT + 1);
        tests_run++;
        if (wdgOut !== 1'b1) begin
            fails++; $display("FAIL prio_setup got=%b exp=1", wdgOut);
        end
        // Second rise is detected on the same edge that reset is sampled.
        wdg = 1'b1;
        tick(LAT - 1);
        rst = 1'b1;
        tick(1);
        tests_run++;
        if (wdgOut !== 1'b0 || kick_cnt !== 3'd0) begin
            fails++; $display("FAIL prio_reset got=%b/%0d exp=0/0", wdgOut, kick_cnt);
        end
        rst = 1'b0;
        tick(LAT + 2);
        tests_run++;
        if (wdgOut !== 1'b0 || kick_cnt !== 3'd0) begin
            fails++; $display("FAIL prio_after got=%b/%0d exp=0/0", wdgOut, kick_cnt);
        end
        wdg = 1'b0;
        tick(2);
    endtask

    initial begin
        #1;
        test_reset();
        test_toggle();
        test_level_at_release();
        test_timeout();
        test_wrap();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule : tb_biestable_t
